sgdmac_desc_fetch: RTL
======================

# sgdmac_desc_fetch

Descriptor fetch engine for the scatter-gather DMAC, directly downstream of the APB configuration block. On the start pulse it reads a chain of 16-byte descriptors from memory over an AXI read channel, hands each non-empty descriptor to the data mover over a valid/ready interface, and waits for the mover to finish before fetching the next. It drives the done status that the configuration block returns through its status register.

## Interface
Parameters:
- DESC_CNT_W, 16, width of the processed-descriptor counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start pulse from the configuration block.
- start_pointer_i  in  32  address of the first descriptor.
- done_o  out  1  high when idle; this is the configuration block's done input.
- err_o  out  1  sticky error flag; cleared by an accepted start.
- desc_cnt_o  out  DESC_CNT_W  number of descriptors fetched since the last accepted start.
- araddr_o  out  32  AXI read address.
- arlen_o  out  4  fixed at 3 (4 beats).
- arsize_o  out  3  fixed at 3'b010.
- arburst_o  out  2  fixed at INCR (2'b01).
- arvalid_o, arready_i  out/in  1  AR handshake.
- rdata_i  in  32  read data.
- rresp_i  in  2  read response.
- rlast_i  in  1  last beat.
- rvalid_i, rready_o  in/out  1  R handshake.
- desc_src_o, desc_dst_o  out  32  source and destination addresses.
- desc_len_o  out  32  byte length.
- desc_valid_o, desc_ready_i  out/in  1  descriptor handoff to the mover.
- xfer_done_i  in  1  one-cycle pulse from the mover when the handed-off descriptor is complete.

## Operation
Descriptor layout (little-endian, 16-byte aligned):
- word0: source address.
- word1: destination address.
- word2: length.
- word3: next pointer. A value of 0 ends the chain.

States:
- IDLE: done_o = 1. When start_i = 1:
  - latch start_pointer_i with bits [3:0] forced to 0 as the current pointer;
  - clear err_o and desc_cnt_o;
  - go to AR.
  - start_i is ignored in every other state.
- AR: arvalid_o = 1 and araddr_o = the current pointer, both held stable until arready_i = 1. Then go to RD.
- RD: rready_o = 1. A 2-bit beat counter selects which register captures rdata_i on each rvalid_i beat.
  - Any rresp_i ≠ 0, or rlast_i arriving on a beat other than beat 3, sets the error flag for this descriptor.
  - Beats after beat 3 are accepted and discarded.
  - On the rlast_i beat, increment desc_cnt_o (saturating) and go to DEC.
- DEC: one-cycle decision.
  - Error flag set: set err_o and go to IDLE.
  - Length = 0: skip the handoff; go to AR if the next pointer ≠ 0, else IDLE.
  - Otherwise go to PUSH.
- PUSH: desc_valid_o = 1, with the desc_* outputs held stable until desc_ready_i = 1. Then go to WAIT.
- WAIT: hold until xfer_done_i = 1. Then load the next pointer (bits [3:0] forced to 0) and go to AR; if the next pointer is 0, go to IDLE instead.

Other rules:
- xfer_done_i is ignored outside WAIT.
- A xfer_done_i pulse in the same cycle as the PUSH handshake is not counted; the block waits for the next pulse.
- A chain that loops back on itself is not detected and runs until reset.

## Timing
Reset values:
- state IDLE, done_o = 1.
- err_o = 0, desc_cnt_o = 0.
- arvalid_o = 0, rready_o = 0, desc_valid_o = 0.
- araddr_o and all desc_* outputs = 0.
- arlen_o, arsize_o and arburst_o are constants.

Asserting rst mid-operation forces the reset values immediately. Any outstanding burst is abandoned; the interconnect shares the same reset.

Latencies:
- start_i in cycle N → arvalid_o high and done_o low in cycle N+1.
- The last R beat in cycle M → DEC in M+1 → desc_valid_o high (or arvalid_o high for a zero-length skip) in M+2.
- xfer_done_i in cycle K → arvalid_o high in K+1, or done_o high in K+1 for the last descriptor.

All outputs are registered, or decoded from state only. There are no combinational paths from input to output.

## Test plan
- Single descriptor: start with pointer 0x1000; memory {0x2000, 0x3000, 64, 0}; mover accepts after 2 cycles; xfer_done_i 10 cycles later → one handoff with src 0x2000, dst 0x3000, len 64; done_o back high the cycle after xfer_done_i; desc_cnt_o = 1; err_o = 0.
- Three-descriptor chain 0x1000 → 0x1040 → 0x1080, with random arready_i, rvalid_i and desc_ready_i stalls → three handoffs in order with correct fields; araddr_o held stable during stalls; desc_cnt_o = 3.
- Zero-length middle descriptor → only two handoffs; desc_cnt_o = 3; no desc_valid_o for the skipped entry.
- rresp_i = 2'b10 on beat 1 of the second descriptor → no handoff for it; err_o = 1 and done_o = 1; the next start clears err_o.
- Unaligned start pointer 0x100C → araddr_o = 0x1000. A start_i pulse issued during WAIT is ignored, and the chain finishes normally.
- rst asserted during RD → all outputs return to their reset values immediately; a subsequent start fetches correctly.

Source files
------------

// File: rtl/sgdmac_desc_fetch.sv
// sgdmac_desc_fetch
// -----------------
// Descriptor fetch engine for the scatter-gather DMAC. On a start pulse it
// walks a linked chain of 16-byte descriptors in memory. For each one it
// issues a single 4-beat AXI read and hands non-empty descriptors to the data
// mover. It then waits for the mover's completion pulse before following the
// next pointer.
//
// Descriptor layout (little-endian, 16-byte aligned):
//   word0 source address, word1 destination address, word2 byte length,
//   word3 next pointer (0 terminates the chain).
//
// Handshake semantics (AR, R and descriptor handoff): a transfer happens on a
// rising clk edge where both valid and ready are high. A source that raises
// valid keeps it high, with its payload unchanged, until that edge.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start_i, start_pointer_i      start pulse and first descriptor address
//   done_o                        high while idle
//   err_o                         sticky error, cleared by an accepted start
//   desc_cnt_o                    descriptors fetched since the accepted start
//   araddr_o .. arready_i         AXI read address channel (fixed 4x32-bit INCR)
//   rdata_i .. rready_o           AXI read data channel
//   desc_src_o/dst_o/len_o        descriptor fields presented to the mover
//   desc_valid_o, desc_ready_i    descriptor handoff handshake
//   xfer_done_i                   mover completion pulse for the handed-off descriptor
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.

module sgdmac_desc_fetch #(
    parameter int DESC_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [31:0]           start_pointer_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DESC_CNT_W-1:0] desc_cnt_o,
    output logic [31:0]           araddr_o,
    output logic [3:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [31:0]           desc_src_o,
    output logic [31:0]           desc_dst_o,
    output logic [31:0]           desc_len_o,
    output logic                  desc_valid_o,
    input  logic                  desc_ready_i,
    input  logic                  xfer_done_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_RD   = 3'd2,
        S_DEC  = 3'd3,
        S_PUSH = 3'd4,
        S_WAIT = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           cur_ptr_q;
    logic [31:0]           next_ptr_q;   // stored with bits [3:0] already cleared
    logic [31:0]           src_q, dst_q, len_q;
    logic [1:0]            beat_q;
    logic                  beat_ovf_q;   // set once beat 3 has been taken; later beats are dropped
    logic                  desc_err_q;   // error seen while reading the current descriptor
    logic                  err_q;
    logic [DESC_CNT_W-1:0] cnt_q;

    logic r_fire;
    logic last_fire;
    logic next_is_zero;

    assign r_fire       = (state_q == S_RD) && rvalid_i;
    assign last_fire    = r_fire && rlast_i;
    assign next_is_zero = (next_ptr_q == 32'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (last_fire) begin
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (desc_err_q) begin
                    state_d = S_IDLE;
                end else if (len_q == 32'd0) begin
                    // Empty descriptor: never shown to the mover.
                    state_d = next_is_zero ? S_IDLE : S_AR;
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (desc_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion pulse coincident with the PUSH handshake
                // arrives while still in PUSH and is therefore not seen here.
                if (xfer_done_i) begin
                    state_d = next_is_zero ? S_IDLE : S_AR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ptr_q  <= 32'd0;
            next_ptr_q <= 32'd0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            len_q      <= 32'd0;
            beat_q     <= 2'd0;
            beat_ovf_q <= 1'b0;
            desc_err_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cur_ptr_q <= {start_pointer_i[31:4], 4'h0};
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        beat_q     <= 2'd0;
                        beat_ovf_q <= 1'b0;
                        desc_err_q <= 1'b0;
                    end
                end
                S_RD: begin
                    if (r_fire) begin
                        if (!beat_ovf_q) begin
                            case (beat_q)
                                2'd0:    src_q      <= rdata_i;
                                2'd1:    dst_q      <= rdata_i;
                                2'd2:    len_q      <= rdata_i;
                                default: next_ptr_q <= {rdata_i[31:4], 4'h0};
                            endcase
                            if (beat_q == 2'd3) begin
                                beat_ovf_q <= 1'b1;
                            end
                            beat_q <= beat_q + 2'd1;
                        end
                        // Bad response, or a burst that ends anywhere but beat 3.
                        if ((rresp_i != 2'b00) ||
                            (rlast_i && (beat_ovf_q || (beat_q != 2'd3)))) begin
                            desc_err_q <= 1'b1;
                        end
                        if (rlast_i && (cnt_q != {DESC_CNT_W{1'b1}})) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_DEC: begin
                    if (desc_err_q) begin
                        err_q <= 1'b1;
                    end else if ((len_q == 32'd0) && !next_is_zero) begin
                        cur_ptr_q <= next_ptr_q;
                    end
                end
                S_WAIT: begin
                    if (xfer_done_i && !next_is_zero) begin
                        cur_ptr_q <= next_ptr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign done_o       = (state_q == S_IDLE);
    assign arvalid_o    = (state_q == S_AR);
    assign rready_o     = (state_q == S_RD);
    assign desc_valid_o = (state_q == S_PUSH);

    assign err_o      = err_q;
    assign desc_cnt_o = cnt_q;
    assign araddr_o   = cur_ptr_q;
    assign arlen_o    = 4'd3;
    assign arsize_o   = 3'b010;
    assign arburst_o  = 2'b01;

    assign desc_src_o = src_q;
    assign desc_dst_o = dst_q;
    assign desc_len_o = len_q;

endmodule
